// File: rtl/i2s_slave_tx.sv
// I2S (Philips) slave transmitter: follows external BCLK/WS and shifts FIFO'd stereo frames out MSB first.
// Latency: physical BCLK fall -> i2s_sd update 3 HCLK; MSB one BCLK after each WS edge.
// Backpressure: s_ready drops while the frame FIFO is full; I2S_TX_MONO_EN sends the left sample in both slots.
module i2s_slave_tx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        en,
    input  logic [DATA_W-1:0]           s_left,
    input  logic [DATA_W-1:0]           s_right,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic                        i2s_bclk,
    input  logic                        i2s_ws,
    output logic                        i2s_sd,
    output logic                        underrun,
    input  logic                        clr_underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_MUTED  = 2'd2
    } state_t;

    function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] smp);
        logic [SLOT_W-1:0] w;
        w = SLOT_W'(smp);
        return w << (SLOT_W - DATA_W);
    endfunction

    state_t            state_q, state_d;
    logic              bclk_meta_q, bclk_meta_d;
    logic              bclk_s_q, bclk_s_d;
    logic              bclk_prev_q, bclk_prev_d;
    logic              ws_meta_q, ws_meta_d;
    logic              ws_s_q, ws_s_d;
    logic              ws_q, ws_d;
    logic [SLOT_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] r_hold_q, r_hold_d;
    logic              sd_q, sd_d;
    logic              underrun_q, underrun_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_l_d [FIFO_DEPTH];
    logic [DATA_W-1:0] rd_left;
    logic [DATA_W-1:0] rd_right;
    logic              bclk_fall;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign bclk_fall  = bclk_prev_q & ~bclk_s_q;
    assign fifo_empty = (level_q == '0);
    assign s_ready    = (level_q != LW'(FIFO_DEPTH));
    assign push       = s_valid & s_ready;
    assign rd_left    = mem_l_q[rd_ptr_q];

    assign i2s_sd     = sd_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

`ifdef I2S_TX_MONO_EN
    logic unused_right;
    assign unused_right = ^s_right;
    assign rd_right     = rd_left;
`else
    logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r_d [FIFO_DEPTH];

    always_comb begin
        mem_r_d = mem_r_q;
        if (push) begin
            mem_r_d[wr_ptr_q] = s_right;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r_q[i] <= '0;
            end
        end else begin
            mem_r_q <= mem_r_d;
        end
    end

    assign rd_right = mem_r_q[rd_ptr_q];
`endif

    // Slot sequencing runs only on synchronized BCLK falls; WS edges load, steady WS shifts.
    always_comb begin
        bclk_meta_d = i2s_bclk;
        bclk_s_d    = bclk_meta_q;
        bclk_prev_d = bclk_s_q;
        ws_meta_d   = i2s_ws;
        ws_s_d      = ws_meta_q;
        ws_d        = ws_q;
        state_d     = state_q;
        shreg_d     = shreg_q;
        r_hold_d    = r_hold_q;
        sd_d        = sd_q;
        underrun_d  = underrun_q & ~clr_underrun;
        pop         = 1'b0;

        if (bclk_fall) begin
            ws_d = ws_s_q;
            if (ws_s_q != ws_q) begin
                if (!ws_s_q) begin
                    if (!en) begin
                        state_d  = ST_MUTED;
                        shreg_d  = '0;
                        r_hold_d = '0;
                    end else if (!fifo_empty) begin
                        state_d  = ST_ACTIVE;
                        pop      = 1'b1;
                        shreg_d  = to_slot(rd_left);
                        r_hold_d = rd_right;
                    end else begin
                        state_d    = ST_ACTIVE;
                        shreg_d    = '0;
                        r_hold_d   = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    shreg_d = (state_q == ST_ACTIVE) ? to_slot(r_hold_q) : '0;
                end
            end else begin
                sd_d    = shreg_q[SLOT_W-1];
                shreg_d = shreg_q << 1;
            end
        end

        if (state_d != ST_ACTIVE) begin
            sd_d = 1'b0;
        end
    end

    always_comb begin
        mem_l_d = mem_l_q;
        if (push) begin
            mem_l_d[wr_ptr_q] = s_left;
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            bclk_meta_q <= 1'b0;
            bclk_s_q    <= 1'b0;
            bclk_prev_q <= 1'b0;
            ws_meta_q   <= 1'b0;
            ws_s_q      <= 1'b0;
            ws_q        <= 1'b0;
            shreg_q     <= '0;
            r_hold_q    <= '0;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_l_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bclk_meta_q <= bclk_meta_d;
            bclk_s_q    <= bclk_s_d;
            bclk_prev_q <= bclk_prev_d;
            ws_meta_q   <= ws_meta_d;
            ws_s_q      <= ws_s_d;
            ws_q        <= ws_d;
            shreg_q     <= shreg_d;
            r_hold_q    <= r_hold_d;
            sd_q        <= sd_d;
            underrun_q  <= underrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_l_q     <= mem_l_d;
        end
    end

endmodule
